// File: rtl/prewitt_window_gen.sv
// rtl/prewitt_window_gen.sv - streaming 3x3 window generator with two line buffers
// Emits one registered window per interior centre pixel, one cycle after its bottom-right pixel.
module prewitt_window_gen #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int PIX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9*PIX_W-1:0]   out_win,
  output logic [15:0]          out_row,
  output logic [15:0]          out_col,
  output logic                 out_sof,
  output logic                 out_eof
);

  localparam int          CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);
  localparam logic [15:0] LAST_COL = 16'(COLS - 1);

  logic [PIX_W-1:0]   lb_a [COLS];
  logic [PIX_W-1:0]   lb_b [COLS];
  logic [15:0]        row;
  logic [15:0]        col;
  logic [CW-1:0]      col_idx;
  logic [PIX_W-1:0]   top;
  logic [PIX_W-1:0]   mid;
  logic               accept;
  logic               take_pixel;
  logic               emit;
  logic [9*PIX_W-1:0] win_next;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign take_pixel = accept && !frame_restart;
  assign emit       = take_pixel && (row >= 16'd2) && (col >= 16'd2);
  assign col_idx    = col[CW-1:0];
  assign top        = lb_a[col_idx];
  assign mid        = lb_b[col_idx];

  // Window register doubles as out_win; it only moves on accept, which cannot happen during a stall.
  always_comb begin
    win_next = out_win;
    for (int r = 0; r < 3; r++) begin
      win_next[(3*r)*PIX_W +: PIX_W]   = out_win[(3*r+1)*PIX_W +: PIX_W];
      win_next[(3*r+1)*PIX_W +: PIX_W] = out_win[(3*r+2)*PIX_W +: PIX_W];
    end
    win_next[2*PIX_W +: PIX_W] = top;
    win_next[5*PIX_W +: PIX_W] = mid;
    win_next[8*PIX_W +: PIX_W] = in_pixel;
  end

  // Line buffers are plain storage; rows 0-1 of a frame never reach the output, so no clear is needed.
  always_ff @(posedge clk) begin
    if (take_pixel) begin
      lb_a[col_idx] <= lb_b[col_idx];
      lb_b[col_idx] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_win   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (frame_restart) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (take_pixel) begin
        out_win <= win_next;
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? 16'd0 : row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_row   <= row - 16'd1;
        out_col   <= col - 16'd1;
        out_sof   <= (row == 16'd2) && (col == 16'd2);
        out_eof   <= (row == LAST_ROW) && (col == LAST_COL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prewitt_window_gen.sv
// tb/tb_prewitt_window_gen.sv - self-checking bench for prewitt_window_gen
// Neighbourhood model over a stored image plus directed literal expectations.
module tb_prewitt_window_gen;

  localparam int R = 4;
  localparam int C = 5;
  localparam int P = 8;
  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  typedef struct {
    logic [71:0] win;
    logic [15:0] row;
    logic [15:0] col;
    logic        sof;
    logic        eof;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_restart;
  logic          in_valid;
  logic          in_ready;
  logic [P-1:0]  in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [9*P-1:0] out_win;
  logic [15:0]   out_row;
  logic [15:0]   out_col;
  logic          out_sof;
  logic          out_eof;

  always #5 clk = ~clk;

  prewitt_window_gen #(.ROWS(R), .COLS(C), .PIX_W(P)) dut (
    .clk(clk), .rst_n(rst_n), .frame_restart(frame_restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_row(out_row), .out_col(out_col), .out_sof(out_sof), .out_eof(out_eof)
  );

  win_t       exp_q[$];
  win_t       got_q[$];
  win_t       prev_out;
  logic [7:0] img[];
  int         mr, mc;
  int         n_vec = 0;
  int         n_err = 0;
  bit         prev_stall, prev_restart, rnd_ready;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Window centred at (cr,cc) taken straight from the stored image.
  function automatic win_t model_window(input int cr, input int cc);
    win_t w;
    w.win = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.win[(3*i+j)*8 +: 8] = img[(cr-1+i)*C + (cc-1+j)];
    w.row = 16'(cr);
    w.col = 16'(cc);
    w.sof = (cr == 1) && (cc == 1);
    w.eof = (cr == R-2) && (cc == C-2);
    return w;
  endfunction

  function automatic win_t current_out();
    win_t w;
    w.win = out_win; w.row = out_row; w.col = out_col; w.sof = out_sof; w.eof = out_eof;
    return w;
  endfunction

  always @(negedge clk) begin
    win_t e, cur;
    cur = current_out();
    if (!rst_n) begin
      exp_q.delete();
      mr = 0; mc = 0;
      prev_stall = 0; prev_restart = 0;
    end else begin
      check("in_ready", 72'(in_ready), 72'(!(out_valid && !out_ready)));
      if (prev_stall && !prev_restart) begin
        check("hold_valid", 72'(out_valid), 72'd1);
        check("hold_win", out_win, prev_out.win);
        check("hold_pos", 72'({out_row, out_col, out_sof, out_eof}),
              72'({prev_out.row, prev_out.col, prev_out.sof, prev_out.eof}));
      end
      if (exp_q.size() > 0) check("latency_valid", 72'(out_valid), 72'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_window", 72'(out_valid), 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("win", out_win, e.win);
          check("centre", 72'({out_row, out_col}), 72'({e.row, e.col}));
          check("sof_eof", 72'({out_sof, out_eof}), 72'({e.sof, e.eof}));
        end
        got_q.push_back(cur);
      end
      prev_stall   = out_valid && !out_ready;
      prev_restart = frame_restart;
      prev_out     = cur;
      if (in_valid && in_ready && !frame_restart) begin
        img[mr*C + mc] = in_pixel;
        if (mr >= 2 && mc >= 2) exp_q.push_back(model_window(mr-1, mc-1));
        mc++;
        if (mc == C) begin
          mc = 0; mr++;
          if (mr == R) mr = 0;
        end
      end
      if (frame_restart) begin
        exp_q.delete();
        mr = 0; mc = 0;
      end
    end
  end

  task automatic send(input logic [7:0] p);
    bit acc;
    int k;
    in_valid = 1'b1; in_pixel = p; acc = 0; k = 0;
    while (!acc && k < 100) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      k++;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 72'(in_ready), 72'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_pixels(input logic [7:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) send(8'(base + 16*(i/C) + (i%C)));
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_first(input string name, input int idx);
    check({name, "_win"}, got_q[idx].win, FIRST_WIN);
    check({name, "_centre"}, 72'({got_q[idx].row, got_q[idx].col}), 72'({16'd1, 16'd1}));
    check({name, "_sof"}, 72'(got_q[idx].sof), 72'd1);
  endtask

  initial begin
    int b;
    img = new[R*C];
    rst_n = 0; frame_restart = 0; in_valid = 0; in_pixel = 0; out_ready = 1; rnd_ready = 0;
    #12;
    check("reset_valid", 72'(out_valid), 72'd0);
    check("reset_win", out_win, 72'd0);
    check("reset_pos", 72'({out_row, out_col, out_sof, out_eof}), 72'd0);
    check("reset_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1; rst_n = 1;

    // Single frame, full throughput
    b = got_q.size();
    send_pixels(8'h00, 0, R*C-1);
    drain(4);
    check("t1_count", 72'(got_q.size() - b), 72'd6);
    check_first("t1_first", b);
    for (int k = 0; k < 6; k++) begin
      check("t1_order", 72'({got_q[b+k].row, got_q[b+k].col}), 72'({16'(1 + k/3), 16'(1 + k%3)}));
      check("t1_eof", 72'(got_q[b+k].eof), 72'(k == 5));
    end

    // Downstream stall of 3 cycles on the first window
    b = got_q.size();
    send_pixels(8'h00, 0, 12);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_in_ready_low", 72'(in_ready), 72'd0);
      check("t2_frozen", out_win, FIRST_WIN);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    send_pixels(8'h00, 13, R*C-1);
    drain(4);
    check("t2_count", 72'(got_q.size() - b), 72'd6);
    for (int k = 0; k < 6; k++)
      check("t2_order", 72'({got_q[b+k].row, got_q[b+k].col}), 72'({16'(1 + k/3), 16'(1 + k%3)}));

    // Two back-to-back frames
    b = got_q.size();
    send_pixels(8'h00, 0, R*C-1);
    send_pixels(8'h80, 0, R*C-1);
    drain(4);
    check("t3_count", 72'(got_q.size() - b), 72'd12);
    check("t3_f2_top_row", 72'(got_q[b+6].win[23:0]), 72'h82_81_80);
    check("t3_f2_sof", 72'(got_q[b+6].sof), 72'd1);

    // Asynchronous reset after pixel (2,3)
    send_pixels(8'h00, 0, 13);
    #2; rst_n = 0; #1;
    check("t4_valid", 72'(out_valid), 72'd0);
    check("t4_win", out_win, 72'd0);
    check("t4_pos", 72'({out_row, out_col, out_sof, out_eof}), 72'd0);
    @(posedge clk); #1; rst_n = 1;
    b = got_q.size();
    send_pixels(8'h00, 0, R*C-1);
    drain(4);
    check("t4_count", 72'(got_q.size() - b), 72'd6);
    check_first("t4_first", b);

    // frame_restart together with pixel (1,4)
    b = got_q.size();
    send_pixels(8'h00, 0, 8);
    in_valid = 1'b1; in_pixel = 8'h14; frame_restart = 1'b1;
    @(posedge clk); #1;
    frame_restart = 1'b0; in_valid = 1'b0;
    drain(3);
    check("t5_no_window", 72'(got_q.size() - b), 72'd0);
    b = got_q.size();
    send_pixels(8'h00, 0, R*C-1);
    drain(4);
    check("t5_count", 72'(got_q.size() - b), 72'd6);
    check_first("t5_first", b);

    // Random pixels, random downstream ready, many frames
    b = got_q.size();
    rnd_ready = 1;
    for (int f = 0; f < 300; f++)
      for (int i = 0; i < R*C; i++) send(8'($urandom_range(0, 255)));
    rnd_ready = 0;
    drain(6);
    check("t6_count", 72'(got_q.size() - b), 72'(300 * (R-2) * (C-2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prewitt_window_gen.md
Name: prewitt_window_gen

Overview:
- Streaming 3x3 neighbourhood generator placed directly upstream of the Prewitt gradient stage.
- Accepts one raster-order 8-bit pixel per handshake, buffers two previous image lines, and emits a registered 3x3 window for every interior centre pixel.
- The downstream Prewitt kernel computes sum_x/sum_y from each window and forces border outputs to 0.
- Replaces whole-image array storage with two line buffers.

Parameters:
ROWS, 242, image height in pixels (>=3)
COLS, 247, image width in pixels (>=3)
PIX_W, 8, pixel width in bits

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
frame_restart  input  1  synchronous; forces row/col counters to (0,0), drops pending output
in_valid  input  1  upstream pixel valid
in_ready  output  1  block can accept a pixel this cycle
in_pixel  input  PIX_W  raster-order pixel, row-major, top-left first
out_valid  output  1  out_win holds a valid window
out_ready  input  1  downstream accepts window
out_win  output  9*PIX_W  window; element (r,c), r,c in 0..2, at bits [(3r+c)*PIX_W +: PIX_W]; r=0 top, c=0 left
out_row  output  16  image row of window centre
out_col  output  16  image column of window centre
out_sof  output  1  window is first of frame (centre 1,1)
out_eof  output  1  window is last of frame (centre ROWS-2,COLS-2)

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_win=0, out_row=0, out_col=0, out_sof=0, out_eof=0.
  - Row/col counters=0; window registers=0. Line-buffer RAM is not cleared.
  - Stale RAM is never exposed because output requires row>=2.
  - Reset mid-frame: the next accepted pixel is treated as (0,0).
- in_ready = !out_valid || out_ready; combinational, no other dependency.
- accept = in_valid && in_ready.
- Line buffers: lb_a holds row r-2, lb_b holds row r-1. Each is COLS x PIX_W. On accept of pixel p at (r,c):
  - top=lb_a[c], mid=lb_b[c], bot=p.
  - lb_a[c]<=lb_b[c]; lb_b[c]<=p.
  - Window shifts left: columns 0<=1, 1<=2; column 2<={top,mid,bot}.
- Counters on accept:
  - c increments; at c==COLS-1, c<=0 and r increments.
  - At (ROWS-1,COLS-1), wrap to (0,0) so the next frame starts with no gap.
- Output emission:
  - On accept with r>=2 and c>=2, next cycle: out_valid=1, out_win=shifted window, out_row=r-1, out_col=c-1.
  - out_sof=(r==2&&c==2); out_eof=(r==ROWS-1&&c==COLS-1).
  - Latency is 1 cycle from accepting pixel (r,c) to the window centred at (r-1,c-1).
- Hold: while out_valid && !out_ready, all out_* are stable and in_ready=0.
- Clear: if out_ready && out_valid and no qualifying accept this cycle, out_valid<=0.
- Simultaneous downstream take and new qualifying accept: out_valid stays 1 and the outputs update. Full throughput is one window per cycle.
- Windows per frame = (ROWS-2)*(COLS-2). No windows are emitted for rows 0-1 or columns 0-1 of the input, which means no border centres.
- Column wrap: at c=0 and c=1 the window shifts in columns from the new row. Output is suppressed until c=2, so no cross-row mixing is visible.
- frame_restart=1:
  - Counters<=(0,0) and out_valid<=0. Any pixel accepted in the same cycle is discarded; restart has priority.
  - Line buffers and window are not cleared.
- Arithmetic: counters are 16-bit unsigned; the block does no pixel arithmetic.

Test Plan:
- ROWS=4, COLS=5, pixel=16r+c, in_valid=1, out_ready=1 constantly:
  - First window 1 cycle after accepting (2,2), with out_win row0={0x00,0x01,0x02}, row1={0x10,0x11,0x12}, row2={0x20,0x21,0x22}, out_row=1, out_col=1, out_sof=1.
  - Exactly 6 windows with centres (1,1)..(2,3); out_eof=1 only on centre (2,3).
- Same stream with out_ready low for 3 cycles while out_valid=1:
  - in_ready=0 during the stall and out_win stays frozen.
  - After release, all 6 windows arrive in order with no loss or duplication.
- Two back-to-back frames, second frame pixel=0x80+16r+c:
  - Second frame's first window is row0={0x80,0x81,0x82} and has out_sof=1.
  - 12 windows total.
- rst_n pulsed low after pixel (2,3):
  - All outputs go to 0 immediately.
  - A fresh frame after release yields correct windows starting at (1,1) with sof.
- frame_restart asserted at pixel (1,4) together with in_valid:
  - That pixel is dropped and no window is emitted.
  - The following full frame produces 6 correct windows.
- Default parameters, random pixels, out_ready random 50%:
  - 58800 windows produced.
  - Each window matches the software 3x3 neighbourhood of image[out_row][out_col].
